radar_pulse_sequencer: RTL and testbench

Pulse-radar timing and waveform controller that drives the sine-ROM DDS datapath. It generates the ROM phase address during each transmit pulse, with a constant frequency or a linear chirp, and a DAC enable aligned to the ROM output. It also produces the ADC receive window and sequences a burst of N pulses at a programmable PRI. It sits between the host/config registers and the sine ROM, DAC and ADC capture logic, all in the 200 MHz domain.

---
 rtl/radar_pulse_sequencer_if.sv | 42 ++++
 rtl/radar_pulse_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_radar_pulse_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/radar_pulse_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : radar_pulse_sequencer_if
// Description : Config, control and waveform-output bundle of the radar pulse
//               sequencer. "master" is the host/driver side, "slave" is the
//               sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface radar_pulse_sequencer_if #(
    parameter int PHASE_W = 11,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               stop;
    logic [CNT_W-1:0]   cfg_pri;
    logic [CNT_W-1:0]   cfg_pw;
    logic [PHASE_W-1:0] cfg_f0;
    logic [PHASE_W-1:0] cfg_kstep;
    logic [CNT_W-1:0]   cfg_rx_dly;
    logic [CNT_W-1:0]   cfg_rx_len;
    logic [CNT_W-1:0]   cfg_npulse;
    logic [PHASE_W-1:0] rom_addr;
    logic               tx_gate;
    logic               dac_en;
    logic               rx_gate;
    logic [CNT_W-1:0]   pulse_idx;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, cfg_pri, cfg_pw, cfg_f0, cfg_kstep,
               cfg_rx_dly, cfg_rx_len, cfg_npulse,
        input  rom_addr, tx_gate, dac_en, rx_gate, pulse_idx, busy, done
    );

    modport slave (
        input  start, stop, cfg_pri, cfg_pw, cfg_f0, cfg_kstep,
               cfg_rx_dly, cfg_rx_len, cfg_npulse,
        output rom_addr, tx_gate, dac_en, rx_gate, pulse_idx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/radar_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : radar_pulse_sequencer
// Description : Pulse-radar timing/waveform controller. Generates the DDS
//               phase address during each TX pulse, a ROM-aligned DAC enable,
//               the ADC receive window, and sequences a burst of pulses at a
//               programmable PRI. Optional linear chirp is compiled in when
//               the macro SEQ_LFM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module radar_pulse_sequencer #(
    parameter int PHASE_W = 11,
    parameter int CNT_W   = 16,
    parameter int ROM_LAT = 1
) (
    input  wire                         clk,
    input  wire                         rst,
    radar_pulse_sequencer_if.slave      bus
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_TX   = 2'd1;
    localparam logic [1:0] C_RX   = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Sequencing state
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_pidx;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_fw;
    logic               r_stop_pend;

    // Burst shadow configuration
    logic [CNT_W-1:0]   r_pri;
    logic [CNT_W-1:0]   r_pw;
    logic [PHASE_W-1:0] r_f0;
    logic [CNT_W-1:0]   r_rx_dly;
    logic [CNT_W-1:0]   r_rx_len;
    logic [CNT_W-1:0]   r_npulse;

    // Registered outputs
    logic [PHASE_W-1:0] r_rom_addr;
    logic               r_tx_gate;
    logic               r_rx_gate;
    logic               r_busy;
    logic               r_done;
    logic               w_dac_en;

    // Next-state values
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cyc_nxt;
    logic [CNT_W-1:0]   w_pidx_nxt;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic [PHASE_W-1:0] w_fw_nxt;
    logic [PHASE_W-1:0] w_fw_step;
    logic               w_stop_pend_nxt;
    logic               w_latch;
    logic               w_end_pri;
    logic               w_last;
    logic [CNT_W-1:0]   w_rx_dly;
    logic [CNT_W-1:0]   w_rx_len;
    logic               w_rx_nxt;

`ifdef SEQ_LFM_EN
    logic [PHASE_W-1:0] r_kstep;

    // Chirp: frequency word ramps by kstep every TX cycle
    always_comb begin
        w_fw_step = r_fw + r_kstep;
    end

    // Chirp-rate shadow register, captured with the rest of the burst config
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kstep <= '0;
        end else if (w_latch) begin
            r_kstep <= bus.cfg_kstep;
        end
    end
`else
    logic w_unused_kstep;
    assign w_unused_kstep = ^bus.cfg_kstep;

    // Fixed-frequency pulse: frequency word holds at f0
    always_comb begin
        w_fw_step = r_fw;
    end
`endif

    assign w_end_pri = (r_cyc == (r_pri - C_CNT_ONE));
    // A stop arriving in the very last PRI cycle still belongs to this PRI
    assign w_last    = ((r_npulse != '0) && (r_pidx == (r_npulse - C_CNT_ONE)))
                     || r_stop_pend || bus.stop;

    // Next-state and counter/phase update logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cyc_nxt       = r_cyc;
        w_pidx_nxt      = r_pidx;
        w_phase_nxt     = r_phase;
        w_fw_nxt        = r_fw;
        w_stop_pend_nxt = r_stop_pend;
        w_latch         = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (bus.start && (bus.cfg_pri != '0)) begin
                    w_latch     = 1'b1;
                    w_cyc_nxt   = '0;
                    w_pidx_nxt  = '0;
                    w_phase_nxt = '0;
                    w_fw_nxt    = bus.cfg_f0;
                    w_state_nxt = (bus.cfg_pw != '0) ? C_TX : C_RX;
                end
            end
            C_TX, C_RX: begin
                if (bus.stop) begin
                    w_stop_pend_nxt = 1'b1;
                end
                if (w_end_pri) begin
                    if (w_last) begin
                        w_state_nxt = C_DONE;
                    end else begin
                        w_cyc_nxt   = '0;
                        w_pidx_nxt  = r_pidx + C_CNT_ONE;
                        w_phase_nxt = '0;
                        w_fw_nxt    = r_f0;
                        w_state_nxt = (r_pw != '0) ? C_TX : C_RX;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + C_CNT_ONE;
                    if (r_state == C_TX) begin
                        w_phase_nxt = r_phase + r_fw;
                        w_fw_nxt    = w_fw_step;
                        if (r_cyc == (r_pw - C_CNT_ONE)) begin
                            w_state_nxt = C_RX;
                        end
                    end
                end
            end
            C_DONE: begin
                w_stop_pend_nxt = 1'b0;
                w_state_nxt     = C_IDLE;
            end
            default: begin
                w_state_nxt = C_IDLE;
            end
        endcase
    end

    // Receive window for the upcoming cycle; the start cycle sees the live cfg
    always_comb begin
        w_rx_dly = w_latch ? bus.cfg_rx_dly : r_rx_dly;
        w_rx_len = w_latch ? bus.cfg_rx_len : r_rx_len;
        w_rx_nxt = ((w_state_nxt == C_TX) || (w_state_nxt == C_RX))
                 && ({1'b0, w_cyc_nxt} >= {1'b0, w_rx_dly})
                 && ({1'b0, w_cyc_nxt} <  ({1'b0, w_rx_dly} + {1'b0, w_rx_len}));
    end

    // Burst shadow registers, captured on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pri    <= '0;
            r_pw     <= '0;
            r_f0     <= '0;
            r_rx_dly <= '0;
            r_rx_len <= '0;
            r_npulse <= '0;
        end else if (w_latch) begin
            r_pri    <= bus.cfg_pri;
            r_pw     <= bus.cfg_pw;
            r_f0     <= bus.cfg_f0;
            r_rx_dly <= bus.cfg_rx_dly;
            r_rx_len <= bus.cfg_rx_len;
            r_npulse <= bus.cfg_npulse;
        end
    end

    // State, counters and registered outputs derived from next-state values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= C_IDLE;
            r_cyc       <= '0;
            r_pidx      <= '0;
            r_phase     <= '0;
            r_fw        <= '0;
            r_stop_pend <= 1'b0;
            r_rom_addr  <= '0;
            r_tx_gate   <= 1'b0;
            r_rx_gate   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cyc       <= w_cyc_nxt;
            r_pidx      <= w_pidx_nxt;
            r_phase     <= w_phase_nxt;
            r_fw        <= w_fw_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_rom_addr  <= (w_state_nxt == C_TX) ? w_phase_nxt : '0;
            r_tx_gate   <= (w_state_nxt == C_TX);
            r_rx_gate   <= w_rx_nxt;
            r_busy      <= (w_state_nxt != C_IDLE);
            r_done      <= (w_state_nxt == C_DONE);
        end
    end

    // DAC enable follows tx_gate by the ROM read latency
    generate
        if (ROM_LAT == 0) begin : g_dac_direct
            assign w_dac_en = r_tx_gate;
        end else begin : g_dac_pipe
            logic [ROM_LAT-1:0] r_dac_pipe;

            // Delay line for tx_gate
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dac_pipe <= '0;
                end else begin
                    r_dac_pipe[0] <= r_tx_gate;
                    for (int i = 1; i < ROM_LAT; i++) begin
                        r_dac_pipe[i] <= r_dac_pipe[i-1];
                    end
                end
            end

            assign w_dac_en = r_dac_pipe[ROM_LAT-1];
        end
    endgenerate

    assign bus.rom_addr  = r_rom_addr;
    assign bus.tx_gate   = r_tx_gate;
    assign bus.dac_en    = w_dac_en;
    assign bus.rx_gate   = r_rx_gate;
    assign bus.pulse_idx = r_pidx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_radar_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_radar_pulse_sequencer
// Description : Self-checking bench for radar_pulse_sequencer. Expected
//               waveforms are computed per cycle from the burst parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_radar_pulse_sequencer;

    localparam int PHASE_W = 11;
    localparam int CNT_W   = 16;
    localparam int ROM_LAT = 1;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    radar_pulse_sequencer_if #(.PHASE_W(PHASE_W), .CNT_W(CNT_W)) bus ();

    radar_pulse_sequencer #(
        .PHASE_W (PHASE_W),
        .CNT_W   (CNT_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #2.5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".tx_gate"},   longint'(bus.tx_gate),   0);
        chk({tag, ".rom_addr"},  longint'(bus.rom_addr),  0);
        chk({tag, ".dac_en"},    longint'(bus.dac_en),    0);
        chk({tag, ".rx_gate"},   longint'(bus.rx_gate),   0);
        chk({tag, ".pulse_idx"}, longint'(bus.pulse_idx), 0);
        chk({tag, ".busy"},      longint'(bus.busy),      0);
        chk({tag, ".done"},      longint'(bus.done),      0);
    endtask

    task automatic scramble_cfg();
        bus.cfg_pri    = CNT_W'($urandom);
        bus.cfg_pw     = CNT_W'($urandom);
        bus.cfg_f0     = PHASE_W'($urandom);
        bus.cfg_kstep  = PHASE_W'($urandom);
        bus.cfg_rx_dly = CNT_W'($urandom);
        bus.cfg_rx_len = CNT_W'($urandom);
        bus.cfg_npulse = CNT_W'($urandom);
    endtask

    // Issue start with the given configuration, then check every cycle of
    // the burst plus the DONE and following idle cycle against the model.
    task automatic run_burst(input string name, input int pri, input int pw,
                             input int f0, input int ks, input int dly,
                             input int len, input int np, input int stop_at,
                             input int restart_at, input bit stop_with_start);
        longint T, t_stop, ks_eff, c, p, ph;
        bit exp_tx, exp_rx, prev_tx;
        @(negedge clk);
        bus.cfg_pri    = CNT_W'(pri);
        bus.cfg_pw     = CNT_W'(pw);
        bus.cfg_f0     = PHASE_W'(f0);
        bus.cfg_kstep  = PHASE_W'(ks);
        bus.cfg_rx_dly = CNT_W'(dly);
        bus.cfg_rx_len = CNT_W'(len);
        bus.cfg_npulse = CNT_W'(np);
        bus.start      = 1'b1;
        bus.stop       = stop_with_start;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        scramble_cfg();
`ifdef SEQ_LFM_EN
        ks_eff = ks;
`else
        ks_eff = 0;
`endif
        T = (np != 0) ? longint'(np) * pri : 64'h7fff_ffff;
        if (stop_at >= 0) begin
            t_stop = (longint'(stop_at) / pri + 1) * pri;
            if (t_stop < T) T = t_stop;
        end
        prev_tx = 1'b0;
        for (longint t = 0; t <= T + 1; t++) begin
            c  = t % pri;
            p  = t / pri;
            exp_tx = (t < T) && (c < pw);
            exp_rx = (t < T) && (c >= dly) && (c < longint'(dly) + len);
            ph = (c * f0 + ks_eff * ((c * (c - 1)) / 2)) % (64'd1 << PHASE_W);
            chk($sformatf("%s.tx_gate@%0d", name, t),  longint'(bus.tx_gate),  longint'(exp_tx));
            chk($sformatf("%s.rom_addr@%0d", name, t), longint'(bus.rom_addr), exp_tx ? ph : 0);
            chk($sformatf("%s.rx_gate@%0d", name, t),  longint'(bus.rx_gate),  longint'(exp_rx));
            chk($sformatf("%s.dac_en@%0d", name, t),   longint'(bus.dac_en),   longint'(prev_tx));
            chk($sformatf("%s.busy@%0d", name, t),     longint'(bus.busy),     longint'(t <= T));
            chk($sformatf("%s.done@%0d", name, t),     longint'(bus.done),     longint'(t == T));
            if (t < T) begin
                chk($sformatf("%s.pulse_idx@%0d", name, t), longint'(bus.pulse_idx), p);
            end
            prev_tx   = exp_tx;
            bus.stop  = (t == stop_at);
            bus.start = (t == restart_at);
            @(negedge clk);
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        int pri, pw, np, sa;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        scramble_cfg();
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_burst("fixed",   100, 20, 102, 0, 30, 50, 3, -1, -1, 1'b0);
        run_burst("chirp",    20,  5,  10, 1,  0,  3, 1, -1, -1, 1'b0);
        run_burst("wrap",     12,  8, 2000, 3, 2,  4, 2, -1, -1, 1'b0);
        run_burst("clip",    100, 10,   5, 0, 90, 50, 1, -1, -1, 1'b0);
        run_burst("contstop", 20,  6,  33, 2,  4, 10, 0, 67, 30, 1'b0);
        run_burst("pw0",      15,  0,  44, 0,  3,  5, 2, -1, -1, 1'b0);
        run_burst("pwlong",  100, 150, 17, 1, 10, 20, 2, -1, -1, 1'b0);
        run_burst("stopstart", 10, 4,  60, 0,  2,  3, 2, -1, -1, 1'b1);
        run_burst("widewin",  16,  3,   9, 0,  5, 16'hFFFF, 2, -1, -1, 1'b0);
        run_burst("pri1",      1,  1, 500, 0,  0,  1, 3, -1, -1, 1'b0);

        // Stop while idle must not shorten the next burst
        @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        run_burst("idlestop", 10, 3, 70, 0, 1, 4, 2, -1, -1, 1'b0);

        // pri=0: start ignored
        @(negedge clk);
        bus.cfg_pri    = '0;
        bus.cfg_pw     = 16'd5;
        bus.cfg_npulse = 16'd1;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pri0.busy@%0d", i),    longint'(bus.busy),    0);
            chk($sformatf("pri0.tx_gate@%0d", i), longint'(bus.tx_gate), 0);
            @(negedge clk);
        end

        // Reset mid-TX clears outputs immediately
        bus.cfg_pri    = 16'd50;
        bus.cfg_pw     = 16'd20;
        bus.cfg_f0     = 11'd77;
        bus.cfg_kstep  = 11'd0;
        bus.cfg_rx_dly = 16'd0;
        bus.cfg_rx_len = 16'd40;
        bus.cfg_npulse = 16'd2;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midtx.tx_gate_pre", longint'(bus.tx_gate), 1);
        chk("midtx.rom_addr_pre", longint'(bus.rom_addr), 5 * 77);
        #1;
        rst = 1'b1;
        #0.5;
        chk_all_zero("midtx_rst");
        @(negedge clk);
        rst = 1'b0;
        run_burst("afterrst", 30, 7, 123, 2, 5, 10, 2, -1, -1, 1'b0);

        // Randomized bursts
        for (int k = 0; k < 12; k++) begin
            pri = $urandom_range(1, 40);
            pw  = $urandom_range(0, 50);
            np  = $urandom_range(1, 3);
            sa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, np * pri - 1) : -1;
            run_burst($sformatf("rand%0d", k), pri, pw, $urandom_range(0, 2047),
                      $urandom_range(0, 2047), $urandom_range(0, 45),
                      $urandom_range(0, 45), np, sa, $urandom_range(0, 20), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
